credit_fifo_tx: RTL and testbench
=================================

Name: credit_fifo_tx

Overview:
- Transmit end of a credit-based link that feeds a remote fifo_base of CREDITS entries, one or more pipeline stages away.
- Accepts words on a valid/ready upstream interface and drives them onto a registered, non-backpressured link (valid + data).
- Tracks free remote slots with a credit counter. The receiver returns one credit per pop.
- Guarantees the remote FIFO never overflows, so the link needs no ready signal.

Parameters:
- DATA_WIDTH, 64, width of each data word.
- CREDITS, 3, remote FIFO depth; initial credit count; must be >= 1.
- CREDIT_WIDTH, $clog2(CREDITS+1), localparam; width of the credit count.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- i__data_in_valid  input  1  upstream word valid.
- i__data_in  input  DATA_WIDTH  upstream word.
- o__data_in_ready  output  1  block accepts a word this cycle.
- o__tx_valid  output  1  link word valid (registered).
- o__tx_data  output  DATA_WIDTH  link word (registered).
- i__credit_return  input  1  one-cycle pulse: the remote FIFO popped one entry.
- i__clear_all  input  1  synchronous clear, asserted in the same cycle as the remote FIFO's i__clear_all.
- o__credits  output  CREDIT_WIDTH  current credit count (registered).
- o__idle  output  1  all credits home and no word in flight on the link.
- o__credit_error  output  1  sticky: a credit was returned while the count was already at CREDITS.

Behaviour:
- Reset is asynchronous and active-high; all state is set on assertion. Reset values:
  - o__tx_valid=0, o__tx_data=0, o__credits=CREDITS, o__credit_error=0.
  - Consequently o__idle=1 and o__data_in_ready=0.
- o__data_in_ready = (r__credits != 0) & ~i__clear_all & ~reset. It is combinational and does not depend on i__data_in_valid.
- send = i__data_in_valid & o__data_in_ready.
- Link register, updated every cycle:
  - o__tx_valid <= send.
  - o__tx_data <= i__data_in when send; otherwise it holds its previous value.
  - Latency is exactly 1 cycle from accept to link.
  - Back-to-back sends produce back-to-back link beats.
- Credit counter next-state:
  - send only: credits-1.
  - credit_return only: credits+1.
  - both in the same cycle: unchanged.
  - neither: unchanged.
- Underflow is impossible because send requires credits != 0.
- Overflow: credit_return with no send while credits==CREDITS. The count saturates at CREDITS and o__credit_error is set; it stays set until reset or i__clear_all.
- Credits observed by o__data_in_ready are the registered value. A credit returned in cycle N enables a send in cycle N+1, not in cycle N.
- i__clear_all has priority over send and credit_return:
  - next cycle: credits=CREDITS, o__tx_valid=0, o__credit_error=0; o__tx_data holds.
  - o__data_in_ready=0 during the clear cycle, so no word is lost silently.
- o__idle = (r__credits == CREDITS) & ~o__tx_valid. This is combinational from registers.
- CREDITS=1 is a legal configuration: at most one word is outstanding, and ready drops for the whole round trip.
- Reset asserted mid-stream discards the in-flight link beat and restores all credits immediately (asynchronous).

Decomposition:
- Shared package pifo_link_pkg holds:
  - the credit-width helper function, f__credit_width(depth) = $clog2(depth+1);
  - a typedef for the link beat struct {valid, data}, parameterised by DATA_WIDTH through the instantiating module.
- One natural sub-module: credit_counter, an up/down saturating counter.
  - Parameters: NUM_CREDITS, COUNT_WIDTH.
  - Ports: clk, reset, i__clear, i__dec, i__inc, o__count, o__count__next, o__overflow.
- The link register and error flag stay in the top module.

Test Plan:
- Reset then idle, CREDITS=3: release reset with no traffic -> o__credits=3, o__idle=1, o__tx_valid=0, o__data_in_ready=1 from the first cycle after release.
- Credit exhaustion: valid held high with data 0xA,0xB,0xC,0xD and no returns -> 0xA/0xB/0xC appear on o__tx_data in cycles 1-3, ready=0 from cycle 3, o__credits=0, 0xD held upstream.
- Credit return unblocks: from the exhausted state, pulse credit_return in cycle N -> ready=1 in N+1, 0xD on the link in N+2, credits back to 0.
- Simultaneous send and return at credits=1 -> credits stays 1, word forwarded, ready stays 1.
- Spurious return at credits=3 -> credits stays 3, o__credit_error=1 and stays set, cleared by i__clear_all next cycle.
- Clear mid-stream at credits=1, with valid high in the clear cycle -> no link beat the following cycle, credits=3, ready=0 during the clear cycle.
- Mid-stream reset -> tx_valid=0 and credits=3 asynchronously.

Source files
------------

// File: rtl/pifo_link_pkg.sv
// Shared definitions for the credit-based link: credit-width helper and the
// link beat layout used by the transmit side.

// The beat struct depends on the instantiating module's DATA_WIDTH, which a
// package cannot take as a parameter, so the layout is provided as a macro
// that the module expands with its own width.
`define PIFO_LINK_BEAT_T(W) struct packed { logic valid; logic [(W)-1:0] data; }

package pifo_link_pkg;

    // Width needed to hold a count from 0 up to and including depth.
    function automatic int f__credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : pifo_link_pkg

// File: rtl/credit_fifo_tx_if.sv
// Signal bundle for credit_fifo_tx: upstream valid/ready, registered link,
// credit return path, clear and status.
//   master : the environment (upstream source and remote receiver)
//   slave  : the credit_fifo_tx block itself

interface credit_fifo_tx_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CREDITS    = 3
);
    import pifo_link_pkg::*;

    localparam int CREDIT_WIDTH = f__credit_width(CREDITS);

    // Upstream handshake
    logic                    i__data_in_valid;
    logic [DATA_WIDTH-1:0]   i__data_in;
    logic                    o__data_in_ready;

    // Link toward the remote FIFO
    logic                    o__tx_valid;
    logic [DATA_WIDTH-1:0]   o__tx_data;

    // Credit return and shared clear
    logic                    i__credit_return;
    logic                    i__clear_all;

    // Status
    logic [CREDIT_WIDTH-1:0] o__credits;
    logic                    o__idle;
    logic                    o__credit_error;

    modport master (
        output i__data_in_valid,
        output i__data_in,
        input  o__data_in_ready,
        input  o__tx_valid,
        input  o__tx_data,
        output i__credit_return,
        output i__clear_all,
        input  o__credits,
        input  o__idle,
        input  o__credit_error
    );

    modport slave (
        input  i__data_in_valid,
        input  i__data_in,
        output o__data_in_ready,
        output o__tx_valid,
        output o__tx_data,
        input  i__credit_return,
        input  i__clear_all,
        output o__credits,
        output o__idle,
        output o__credit_error
    );

endinterface : credit_fifo_tx_if

// File: rtl/credit_counter.sv
// Up/down credit counter that resets and clears to NUM_CREDITS, saturates
// at NUM_CREDITS and flags an attempted increment past that value.

module credit_counter #(
    parameter int NUM_CREDITS = 3,
    parameter int COUNT_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i__clear,
    input  logic                   i__dec,
    input  logic                   i__inc,
    output logic [COUNT_WIDTH-1:0] o__count,
    output logic [COUNT_WIDTH-1:0] o__count__next,
    output logic                   o__overflow
);

    localparam logic [COUNT_WIDTH-1:0] FULL = COUNT_WIDTH'(NUM_CREDITS);

    // Next count: clear wins; a simultaneous inc and dec cancel out.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        o__count__next = o__count;
        o__overflow    = 1'b0;
        if (i__clear) begin
            o__count__next = FULL;
        end else if (i__dec && !i__inc) begin
            o__count__next = o__count - 1'b1;
        end else if (i__inc && !i__dec) begin
            if (o__count == FULL) begin
                o__overflow = 1'b1;
            end else begin
                o__count__next = o__count + 1'b1;
            end
        end
    end

    // Count register; reset returns all credits home.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples its inputs from before this clock edge.
        if (reset) begin
            o__count <= FULL;
        end else begin
            o__count <= o__count__next;
        end
    end

endmodule : credit_counter

// File: rtl/credit_fifo_tx.sv
// Transmit end of a credit-based link. Words are accepted upstream only
// while a remote FIFO slot is known to be free, so the registered link
// never needs backpressure.

module credit_fifo_tx
    import pifo_link_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CREDITS    = 3
) (
    input  logic             clk,
    input  logic             reset,
    credit_fifo_tx_if.slave  bus
);

    localparam int CREDIT_WIDTH = f__credit_width(CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] FULL_CREDITS = CREDIT_WIDTH'(CREDITS);

    typedef `PIFO_LINK_BEAT_T(DATA_WIDTH) link_beat_t;

    link_beat_t              r__beat;
    logic [CREDIT_WIDTH-1:0] r__credits;
    logic [CREDIT_WIDTH-1:0] credits_next;
    logic                    r__credit_error;
    logic                    overflow;
    logic                    send;

    // Ready looks only at the registered count: a credit returned this cycle
    // can be spent next cycle. Clear and reset both block acceptance.
    assign bus.o__data_in_ready = (r__credits != '0) & ~bus.i__clear_all & ~reset;
    assign send                 = bus.i__data_in_valid & bus.o__data_in_ready;

    credit_counter #(
        .NUM_CREDITS (CREDITS),
        .COUNT_WIDTH (CREDIT_WIDTH)
    ) u_credit_counter (
        .clk            (clk),
        .reset          (reset),
        .i__clear       (bus.i__clear_all),
        .i__dec         (send),
        .i__inc         (bus.i__credit_return),
        .o__count       (r__credits),
        .o__count__next (credits_next),
        .o__overflow    (overflow)
    );

    // Link register: one-cycle launch of each accepted word; data holds
    // between beats. Clear never coincides with a send since ready is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r__beat <= '0;
        end else begin
            r__beat.valid <= send;
            if (send) begin
                r__beat.data <= bus.i__data_in;
            end
        end
    end

    // Sticky overflow flag, cleared only by reset or clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r__credit_error <= 1'b0;
        end else if (bus.i__clear_all) begin
            r__credit_error <= 1'b0;
        end else if (overflow) begin
            r__credit_error <= 1'b1;
        end
    end

    assign bus.o__tx_valid     = r__beat.valid;
    assign bus.o__tx_data      = r__beat.data;
    assign bus.o__credits      = r__credits;
    assign bus.o__credit_error = r__credit_error;
    assign bus.o__idle         = (r__credits == FULL_CREDITS) & ~r__beat.valid;

    // The counter saturates, so its next value never exceeds the depth.
    a_credits_bounded : assert property (
        @(posedge clk) disable iff (reset) credits_next <= FULL_CREDITS
    );

endmodule : credit_fifo_tx

// File: tb/tb_credit_fifo_tx.sv
// Self-checking bench for credit_fifo_tx: directed scenarios followed by
// random traffic, compared against an outstanding-word model of the link.

module tb_credit_fifo_tx;

    localparam int DW      = 64;
    localparam int CREDITS = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    credit_fifo_tx_if #(.DATA_WIDTH(DW), .CREDITS(CREDITS)) bus ();

    credit_fifo_tx #(.DATA_WIDTH(DW), .CREDITS(CREDITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference state: words sent whose credit has not come back yet,
    // the beat expected on the link and the sticky error.
    int          outstanding;
    logic        exp_tx_valid;
    logic [DW-1:0] exp_tx_data;
    logic        exp_error;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        outstanding  = 0;
        exp_tx_valid = 1'b0;
        exp_tx_data  = '0;
        exp_error    = 1'b0;
    endtask

    task automatic check_regs();
        check("tx_valid", DW'(bus.o__tx_valid), DW'(exp_tx_valid));
        check("tx_data", bus.o__tx_data, exp_tx_data);
        check("credits", DW'(bus.o__credits), DW'(CREDITS - outstanding));
        check("idle", DW'(bus.o__idle), DW'(outstanding == 0 && !exp_tx_valid));
        check("credit_error", DW'(bus.o__credit_error), DW'(exp_error));
    endtask

    // One clock cycle: drive at the falling edge, check ready before the
    // rising edge, advance the model, check registers at the next fall.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic ret, input logic clr);
        logic exp_ready;
        logic accepted;
        bus.i__data_in_valid = v;
        bus.i__data_in       = d;
        bus.i__credit_return = ret;
        bus.i__clear_all     = clr;
        #1;
        exp_ready = (outstanding < CREDITS) && !clr;
        check("ready", DW'(bus.o__data_in_ready), DW'(exp_ready));
        accepted = v && exp_ready;
        @(posedge clk);
        if (clr) begin
            outstanding  = 0;
            exp_tx_valid = 1'b0;
            exp_error    = 1'b0;
        end else begin
            if (ret && !accepted && outstanding == 0) exp_error = 1'b1;
            outstanding = outstanding + int'(accepted) - int'(ret);
            if (outstanding < 0) outstanding = 0;
            exp_tx_valid = accepted;
            if (accepted) exp_tx_data = d;
        end
        @(negedge clk);
        check_regs();
    endtask

    // Reset asserted between edges must act immediately.
    task automatic async_reset();
        #2;
        bus.i__data_in_valid = 1'b0;
        bus.i__credit_return = 1'b0;
        bus.i__clear_all     = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_tx_valid", DW'(bus.o__tx_valid), '0);
        check("rst_credits", DW'(bus.o__credits), DW'(CREDITS));
        check("rst_ready", DW'(bus.o__data_in_ready), '0);
        check("rst_idle", DW'(bus.o__idle), DW'(1));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic          v;
        logic          r;
        logic          c;
        logic [DW-1:0] d;

        reset                = 1'b1;
        bus.i__data_in_valid = 1'b0;
        bus.i__data_in       = '0;
        bus.i__credit_return = 1'b0;
        bus.i__clear_all     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_regs();
        check("rst_ready_held", DW'(bus.o__data_in_ready), '0);
        reset = 1'b0;

        // Idle after reset; ready from the first cycle.
        step(1'b0, '0, 1'b0, 1'b0);
        check("idle_credits", DW'(bus.o__credits), DW'(3));

        // Exhaustion: A, B, C go out, D is held.
        step(1'b1, DW'(64'hA), 1'b0, 1'b0);
        step(1'b1, DW'(64'hB), 1'b0, 1'b0);
        step(1'b1, DW'(64'hC), 1'b0, 1'b0);
        check("exhaust_credits", DW'(bus.o__credits), '0);
        check("exhaust_data", bus.o__tx_data, DW'(64'hC));
        step(1'b1, DW'(64'hD), 1'b0, 1'b0);
        check("exhaust_held", DW'(bus.o__tx_valid), '0);

        // A return in cycle N enables D in N+1.
        step(1'b1, DW'(64'hD), 1'b1, 1'b0);
        step(1'b1, DW'(64'hD), 1'b0, 1'b0);
        check("unblock_data", bus.o__tx_data, DW'(64'hD));
        check("unblock_credits", DW'(bus.o__credits), '0);

        // Bring credits to 1, then send and return together.
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, DW'(64'hE), 1'b1, 1'b0);
        check("simul_credits", DW'(bus.o__credits), DW'(1));
        check("simul_valid", DW'(bus.o__tx_valid), DW'(1));

        // Spurious return at full credits: sticky error, cleared by clear.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("spur_error", DW'(bus.o__credit_error), DW'(1));
        check("spur_credits", DW'(bus.o__credits), DW'(3));
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        check("spur_cleared", DW'(bus.o__credit_error), '0);

        // Clear mid-stream at credits=1 with valid high.
        step(1'b1, DW'(64'h11), 1'b0, 1'b0);
        step(1'b1, DW'(64'h22), 1'b0, 1'b0);
        step(1'b1, DW'(64'h55), 1'b0, 1'b1);
        check("clr_no_beat", DW'(bus.o__tx_valid), '0);
        check("clr_data_hold", bus.o__tx_data, DW'(64'h22));

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
                async_reset();
            end
            v = ($urandom_range(0, 9) < 7);
            d = {$urandom, $urandom};
            if (outstanding > 0) r = ($urandom_range(0, 1) == 1);
            else r = ($urandom_range(0, 49) == 0);
            c = ($urandom_range(0, 59) == 0);
            step(v, d, r, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_credit_fifo_tx
